// File: rtl/general_register_freelist_ctrl_pkg.sv
// Shared scheduler constants and helpers for the physical-register free list.
// Sizes here set the free-list depth, name width and occupancy counter width.
package general_register_freelist_ctrl_pkg;

  localparam int FL_DEPTH = 64;
  localparam int FL_PTR_W = 6;
  localparam int FL_CNT_W = 7;

  typedef logic [FL_PTR_W-1:0] regname_t;
  typedef logic [FL_CNT_W-1:0] flcount_t;
  typedef logic [1:0]          slot_cnt_t;

  // Slot 1 may only pop together with slot 0, and never from an empty slot.
  function automatic slot_cnt_t pop_count(input logic req0, input logic req1,
                                          input logic vld0, input logic vld1);
    if (!(req0 && vld0)) return 2'd0;
    return (req1 && vld1) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/general_register_freelist_ctrl_rr_select2.sv
// Two-winner round-robin select: first and second set request at or after ptr_i.
// Purely combinational; allow_i caps the number of winners at 0, 1 or 2.
module freelist_rr_select2 #(
  parameter int DEPTH = general_register_freelist_ctrl_pkg::FL_DEPTH,
  parameter int PTR_W = general_register_freelist_ctrl_pkg::FL_PTR_W
) (
  input  logic [DEPTH-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [1:0]       allow_i,
  output logic [DEPTH-1:0] gnt0_oh_o,
  output logic [DEPTH-1:0] gnt1_oh_o,
  output logic [PTR_W-1:0] gnt0_idx_o,
  output logic [PTR_W-1:0] gnt1_idx_o,
  output logic             gnt0_vld_o,
  output logic             gnt1_vld_o
);

  logic [DEPTH-1:0] rot;
  logic [PTR_W-1:0] off0;
  logic [PTR_W-1:0] off1;
  logic             hit0;
  logic             hit1;

  // Rotate so that bit 0 is the request at ptr_i; offsets wrap mod DEPTH.
  always_comb begin
    rot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rot[i] = req_i[PTR_W'(i) + ptr_i];
    end
  end

  always_comb begin
    hit0 = 1'b0;
    off0 = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rot[i]) begin
        hit0 = 1'b1;
        off0 = PTR_W'(i);
      end
    end
  end

  always_comb begin
    hit1 = 1'b0;
    off1 = '0;
    for (int i = DEPTH-1; i >= 1; i--) begin
      if (rot[i] && (PTR_W'(i) > off0)) begin
        hit1 = 1'b1;
        off1 = PTR_W'(i);
      end
    end
  end

  assign gnt0_vld_o = hit0 && (allow_i != 2'd0);
  assign gnt1_vld_o = hit1 && (allow_i >= 2'd2);
  assign gnt0_idx_o = off0 + ptr_i;
  assign gnt1_idx_o = off1 + ptr_i;
  assign gnt0_oh_o  = gnt0_vld_o ? (DEPTH'(1) << gnt0_idx_o) : '0;
  assign gnt1_oh_o  = gnt1_vld_o ? (DEPTH'(1) << gnt1_idx_o) : '0;

endmodule

// File: rtl/general_register_freelist_ctrl.sv
// Free list of physical register names: round-robin collects up to 2 freed names per cycle, rename pops up to 2.
// Grants are combinational and throttled by free space; pushed names reach the head one cycle later.
module general_register_freelist_ctrl #(
  parameter int FL_DEPTH = general_register_freelist_ctrl_pkg::FL_DEPTH,
  parameter int FL_PTR_W = general_register_freelist_ctrl_pkg::FL_PTR_W,
  parameter int FL_CNT_W = general_register_freelist_ctrl_pkg::FL_CNT_W
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iFREE_RESTART,
  input  logic [FL_DEPTH-1:0] iENTRY_FREELIST_REQ,
  output logic [FL_DEPTH-1:0] oENTRY_FREELIST_REGIST_VALID,
  input  logic                iALLOC_0_REQ,
  input  logic                iALLOC_1_REQ,
  output logic                oALLOC_0_VALID,
  output logic                oALLOC_1_VALID,
  output logic [FL_PTR_W-1:0] oALLOC_0_REGNAME,
  output logic [FL_PTR_W-1:0] oALLOC_1_REGNAME,
  output logic [FL_CNT_W-1:0] oFREELIST_COUNT
);

  import general_register_freelist_ctrl_pkg::*;

  localparam logic [FL_PTR_W-1:0] PTR_ONE = FL_PTR_W'(1);

  logic [FL_PTR_W-1:0] fl_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] rptr_q, rptr_d;
  logic [FL_PTR_W-1:0] wptr_q, wptr_d;
  logic [FL_PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [FL_CNT_W-1:0] count_q, count_d;

  slot_cnt_t           allow;
  slot_cnt_t           n_push;
  slot_cnt_t           n_pop;
  logic [FL_DEPTH-1:0] g0_oh, g1_oh;
  logic [FL_PTR_W-1:0] g0_idx, g1_idx;
  logic                g0_vld, g1_vld;
  logic                alloc0_vld, alloc1_vld;

  // Never accept more names than there are empty slots; restart blocks all grants.
  always_comb begin
    allow = 2'd2;
    if (iFREE_RESTART || (count_q >= FL_CNT_W'(FL_DEPTH))) begin
      allow = 2'd0;
    end else if (count_q == FL_CNT_W'(FL_DEPTH-1)) begin
      allow = 2'd1;
    end
  end

  freelist_rr_select2 #(
    .DEPTH (FL_DEPTH),
    .PTR_W (FL_PTR_W)
  ) u_rr_select2 (
    .req_i      (iENTRY_FREELIST_REQ),
    .ptr_i      (rr_ptr_q),
    .allow_i    (allow),
    .gnt0_oh_o  (g0_oh),
    .gnt1_oh_o  (g1_oh),
    .gnt0_idx_o (g0_idx),
    .gnt1_idx_o (g1_idx),
    .gnt0_vld_o (g0_vld),
    .gnt1_vld_o (g1_vld)
  );

  assign alloc0_vld = (count_q != '0);
  assign alloc1_vld = (count_q >= FL_CNT_W'(2));
  assign n_push     = {1'b0, g0_vld} + {1'b0, g1_vld};
  assign n_pop      = pop_count(iALLOC_0_REQ, iALLOC_1_REQ, alloc0_vld, alloc1_vld);

  always_comb begin
    rptr_d   = rptr_q + FL_PTR_W'(n_pop);
    wptr_d   = wptr_q + FL_PTR_W'(n_push);
    count_d  = count_q + FL_CNT_W'(n_push) - FL_CNT_W'(n_pop);
    rr_ptr_d = rr_ptr_q;
    if (g1_vld) begin
      rr_ptr_d = g1_idx + PTR_ONE;
    end else if (g0_vld) begin
      rr_ptr_d = g0_idx + PTR_ONE;
    end
    if (iFREE_RESTART) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A second grant only exists alongside a first, so it always lands at wptr+1.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= '0;
      end
    end else begin
      if (g0_vld) begin
        fl_q[wptr_q] <= g0_idx;
      end
      if (g1_vld) begin
        fl_q[wptr_q + PTR_ONE] <= g1_idx;
      end
    end
  end

  assign oENTRY_FREELIST_REGIST_VALID = g0_oh | g1_oh;
  assign oALLOC_0_VALID               = alloc0_vld;
  assign oALLOC_1_VALID               = alloc1_vld;
  assign oALLOC_0_REGNAME             = fl_q[rptr_q];
  assign oALLOC_1_REGNAME             = fl_q[rptr_q + PTR_ONE];
  assign oFREELIST_COUNT              = count_q;

endmodule

// File: tb/tb_general_register_freelist_ctrl.sv
// Directed scoreboard bench for general_register_freelist_ctrl.
// Stimulus queues the expected outputs for each cycle; a monitor compares them at the falling edge.
module tb_general_register_freelist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic [63:0] req;
  logic        a0, a1;
  logic [63:0] gnt;
  logic        v0, v1;
  logic [5:0]  n0, n1;
  logic [6:0]  cnt;

  always #5 clk = ~clk;

  general_register_freelist_ctrl dut (
    .iCLOCK                       (clk),
    .inRESET                      (rst_n),
    .iFREE_RESTART                (restart),
    .iENTRY_FREELIST_REQ          (req),
    .oENTRY_FREELIST_REGIST_VALID (gnt),
    .iALLOC_0_REQ                 (a0),
    .iALLOC_1_REQ                 (a1),
    .oALLOC_0_VALID               (v0),
    .oALLOC_1_VALID               (v1),
    .oALLOC_0_REGNAME             (n0),
    .oALLOC_1_REGNAME             (n1),
    .oFREELIST_COUNT              (cnt)
  );

  typedef struct packed {
    logic [63:0] tag;
    logic [63:0] gnt;
    logic [6:0]  cnt;
    logic        v0;
    logic        v1;
    logic [5:0]  n0;
    logic [5:0]  n1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input logic [63:0] tag, input logic [63:0] what,
                     input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %0s %0s actual=%0h required=%0h", tag, what, act, want);
    end
  endtask

  function automatic logic [63:0] bits2(input int a, input int b);
    logic [63:0] v;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic [63:0] tag, input logic [63:0] r,
                      input logic p0, input logic p1, input logic rs,
                      input logic [63:0] eg, input int ec,
                      input logic ev0, input logic ev1, input int en0, input int en1);
    exp_t e;
    req     = r;
    a0      = p0;
    a1      = p1;
    restart = rs;
    e.tag = tag;
    e.gnt = eg;
    e.cnt = 7'(ec);
    e.v0  = ev0;
    e.v1  = ev1;
    e.n0  = 6'(en0);
    e.n1  = 6'(en1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one queued expectation per stimulus cycle, checked mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.tag, "grant", gnt, e.gnt);
        cmp(e.tag, "count", 64'(cnt), 64'(e.cnt));
        cmp(e.tag, "valid0", 64'(v0), 64'(e.v0));
        cmp(e.tag, "valid1", 64'(v1), 64'(e.v1));
        cmp(e.tag, "name0", 64'(n0), 64'(e.n0));
        cmp(e.tag, "name1", 64'(n1), 64'(e.n1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] three;
    rst_n   = 1'b0;
    restart = 1'b0;
    req     = '0;
    a0      = 1'b0;
    a1      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("rst", 64'h0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);

    // Upper half frees two names per cycle from rr_ptr=0.
    for (int k = 0; k < 16; k++) begin
      step("fill28", 64'hFFFF_FFFF_0000_0000, 0, 0, 0, bits2(32+2*k, 33+2*k),
           2*k, k > 0, k > 0, (k > 0) ? 32 : 0, (k > 0) ? 33 : 0);
    end
    step("drop28", 64'h0, 0, 0, 0, 64'h0, 32, 1, 1, 32, 33);

    // Ordering around the round-robin pointer.
    step("rr0ord", bits2(10, 50), 0, 0, 0, bits2(10, 50), 32, 1, 1, 32, 33);
    step("only60", bits2(60, 60), 0, 0, 0, bits2(60, 60), 34, 1, 1, 32, 33);
    step("wrap29", bits2(5, 60), 0, 0, 0, bits2(5, 60), 35, 1, 1, 32, 33);
    step("rr61", bits2(60, 62), 0, 0, 0, bits2(60, 62), 37, 1, 1, 32, 33);
    step("a1only", 64'h0, 0, 1, 0, 64'h0, 39, 1, 1, 32, 33);

    // Drain two per cycle; the last double pop finds only one name.
    for (int j = 0; j < 16; j++) begin
      step("drain", 64'h0, 1, 1, 0, 64'h0, 39-2*j, 1, 1, 32+2*j, 33+2*j);
    end
    step("ord10", 64'h0, 1, 1, 0, 64'h0, 7, 1, 1, 10, 50);
    step("ord5", 64'h0, 1, 1, 0, 64'h0, 5, 1, 1, 60, 5);
    step("ord62", 64'h0, 1, 1, 0, 64'h0, 3, 1, 1, 60, 62);
    step("pop31", 64'h0, 1, 1, 0, 64'h0, 1, 1, 0, 60, 0);
    step("empty31", 64'h0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);

    // Build count=20, then restart with live requests and pops.
    for (int k = 0; k < 10; k++) begin
      step("fill33", bits2(2*k, 2*k+1), 0, 0, 0, bits2(2*k, 2*k+1),
           2*k, k > 0, k > 0, 0, (k > 0) ? 1 : 0);
    end
    step("restart", bits2(30, 31), 1, 1, 1, 64'h0, 20, 1, 1, 0, 1);
    step("post33", bits2(30, 31), 0, 0, 0, bits2(30, 31), 0, 0, 0, 32, 33);

    // Stream through the ring so rptr lands on 63 with ten names stored.
    for (int c = 0; c < 31; c++) begin
      step("rot32", bits2(2*c+2, 2*c+3), 1, 1, 0, bits2(2*c+2, 2*c+3), 2, 1, 1,
           (c == 0) ? 30 : 2*c, (c == 0) ? 31 : 2*c+1);
    end
    step("pop1", 64'h0, 1, 0, 0, 64'h0, 2, 1, 1, 62, 63);
    for (int p = 0; p < 4; p++) begin
      step("refill", bits2(2*p, 2*p+1), 0, 0, 0, bits2(2*p, 2*p+1), 1+2*p,
           1, p > 0, 63, (p == 0) ? 30 : 0);
    end
    step("refill8", bits2(8, 8), 0, 0, 0, bits2(8, 8), 9, 1, 1, 63, 0);
    step("wrap32", bits2(9, 10), 1, 1, 0, bits2(9, 10), 10, 1, 1, 63, 0);
    step("post32", 64'h0, 0, 0, 0, 64'h0, 10, 1, 1, 1, 2);

    // Fill to 63, then three requesters get a single grant and the list saturates.
    for (int c = 0; c < 26; c++) begin
      step("fill30", bits2(11+2*c, 12+2*c), 0, 0, 0, bits2(11+2*c, 12+2*c),
           10+2*c, 1, 1, 1, 2);
    end
    step("fill63", bits2(63, 63), 0, 0, 0, bits2(63, 63), 62, 1, 1, 1, 2);
    three = bits2(1, 7) | bits2(20, 20);
    step("one30", three, 0, 0, 0, bits2(1, 1), 63, 1, 1, 1, 2);
    step("full30", three, 0, 0, 0, 64'h0, 64, 1, 1, 1, 2);
    step("full30b", three, 0, 0, 0, 64'h0, 64, 1, 1, 1, 2);
    step("rsfull", 64'h0, 0, 0, 1, 64'h0, 64, 1, 1, 1, 2);
    step("rsdone", 64'h0, 0, 0, 0, 64'h0, 0, 0, 0, 1, 1);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
